arbiter_priority_8: RTL and testbench

Eight-way arbiter sharing one downstream resource (bus, display, or shared encoder datapath) between eight requesters. Requests are active-low in the same convention as the lab's priority-encoder inputs. Channel 7 has the highest fixed priority, and a round-robin mode is selectable. The block issues one registered one-hot grant, holds it while the requester keeps requesting, and forcibly revokes it after a bounded hold time.

---
 rtl/arbiter_pkg.sv | 19 +
 rtl/picker_priority_8.sv | 39 +++
 rtl/arbiter_priority_8.sv | 115 +++++++++++
 tb/tb_arbiter_priority_8.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and constants for the eight-way arbiter and its picker.
// index_to_onehot is the single place where a channel index becomes a grant vector.
package arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbState_t;

    localparam int NUM_REQUESTERS = 8;
    localparam int INDEX_WIDTH    = 3;

    function automatic logic [NUM_REQUESTERS-1:0] index_to_onehot(
        input logic [INDEX_WIDTH-1:0] idx
    );
        return NUM_REQUESTERS'(1) << idx;
    endfunction

endpackage

// File: rtl/picker_priority_8.sv
// Combinational winner picker: rotate the active vector, fixed-priority encode, un-rotate.
// Rotation puts channel (start-1) at bit 7 so the descending search starts there.
module picker_priority_8
    import arbiter_pkg::*;
(
    input  logic [NUM_REQUESTERS-1:0] active_i,
    input  logic [INDEX_WIDTH-1:0]    start_i,
    input  logic                      rotate_i,
    output logic                      found_o,
    output logic [INDEX_WIDTH-1:0]    index_o
);

    logic [INDEX_WIDTH-1:0]    shift;
    logic [NUM_REQUESTERS-1:0] rotated;
    logic [INDEX_WIDTH-1:0]    rot_idx;

    // Fixed mode is the rotating search with a zero start, i.e. plain 7-highest.
    assign shift = rotate_i ? start_i : '0;

    always_comb begin
        rotated = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            rotated[i] = active_i[INDEX_WIDTH'(i) + shift];
        end
    end

    always_comb begin
        rot_idx = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (rotated[i]) begin
                rot_idx = INDEX_WIDTH'(i);
            end
        end
    end

    assign found_o = |active_i;
    assign index_o = rot_idx + shift;

endmodule

// File: rtl/arbiter_priority_8.sv
// Eight-way arbiter with active-low requests, fixed or round-robin priority,
// registered one-hot grant and forced revocation after MAX_HOLD cycles.
module arbiter_priority_8
    import arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       enableN,
    input  logic       roundRobin,
    input  logic [7:0] requestN,
    output logic [7:0] grant,
    output logic [2:0] grantIndex,
    output logic       grantValid,
    output logic       timeout,
    output logic       debugState
);

    localparam int                HOLD_W     = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    arbState_t              state_q, state_d;
    logic [INDEX_WIDTH-1:0] owner_q, owner_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [INDEX_WIDTH-1:0] pointer_q, pointer_d;
    logic [INDEX_WIDTH-1:0] mask_idx_q, mask_idx_d;
    logic                   mask_valid_q, mask_valid_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_REQUESTERS-1:0] active;
    logic [NUM_REQUESTERS-1:0] unmasked_others;
    logic                      pick_found;
    logic [INDEX_WIDTH-1:0]    pick_idx;

    // A timed-out channel sits out one arbitration, unless it is the only requester.
    always_comb begin
        active          = ~requestN;
        unmasked_others = active & ~index_to_onehot(mask_idx_q);
        if (mask_valid_q && (|unmasked_others)) begin
            active = unmasked_others;
        end
    end

    picker_priority_8 u_picker (
        .active_i (active),
        .start_i  (pointer_q),
        .rotate_i (roundRobin),
        .found_o  (pick_found),
        .index_o  (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        hold_d       = hold_q;
        pointer_d    = pointer_q;
        mask_idx_d   = mask_idx_q;
        mask_valid_d = mask_valid_q;
        timeout_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                mask_valid_d = 1'b0;
                if (!enableN && pick_found) begin
                    state_d   = GRANT;
                    owner_d   = pick_idx;
                    hold_d    = HOLD_ONE;
                    pointer_d = pick_idx;
                end
            end
            GRANT: begin
                // Release wins over timeout when both happen on the same cycle.
                if (requestN[owner_q]) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_LIMIT) begin
                    state_d      = IDLE;
                    mask_idx_d   = owner_q;
                    mask_valid_d = 1'b1;
                    timeout_d    = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            hold_q       <= '0;
            pointer_q    <= '0;
            mask_idx_q   <= '0;
            mask_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            hold_q       <= hold_d;
            pointer_q    <= pointer_d;
            mask_idx_q   <= mask_idx_d;
            mask_valid_q <= mask_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign grantValid = (state_q == GRANT);
    assign grant      = grantValid ? index_to_onehot(owner_q) : '0;
    assign grantIndex = grantValid ? owner_q : '0;
    assign timeout    = timeout_q;
    assign debugState = state_q;

endmodule

// File: tb/tb_arbiter_priority_8.sv
// Bench for arbiter_priority_8: reference model feeds an expected queue each clock,
// a monitor pops and compares on the falling edge; directed scenarios check grant order.
module tb_arbiter_priority_8;

    localparam int MAX_HOLD = 4;

    logic       clock      = 1'b0;
    logic       resetN     = 1'b0;
    logic       enableN    = 1'b1;
    logic       roundRobin = 1'b0;
    logic [7:0] requestN   = 8'hFF;
    logic [7:0] grant;
    logic [2:0] grantIndex;
    logic       grantValid;
    logic       timeout;
    logic       debugState;

    int checks = 0;
    int errors = 0;

    // Expected word: {state, grant[7:0], index[2:0], valid, timeout}
    logic [13:0] exp_q[$];

    int   own_log[$];
    int   len_log[$];
    int   to_count   = 0;
    int   run_len    = 0;
    logic prev_valid = 1'b0;

    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 0;
    int m_mask  = -1;

    arbiter_priority_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .enableN    (enableN),
        .roundRobin (roundRobin),
        .requestN   (requestN),
        .grant      (grant),
        .grantIndex (grantIndex),
        .grantValid (grantValid),
        .timeout    (timeout),
        .debugState (debugState)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- check helper ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int own_at(input int i);
        return (i < own_log.size()) ? own_log[i] : -1;
    endfunction

    function automatic int len_at(input int i);
        return (i < len_log.size()) ? len_log[i] : -1;
    endfunction

    // ---------------- reference model ----------------
    function automatic int pick_winner(input logic [7:0] cand, input logic rr, input int last);
        int w;
        int c;
        w = -1;
        if (!rr) begin
            for (int i = 7; i >= 0; i--) begin
                if (cand[i] && w < 0) w = i;
            end
        end else begin
            for (int k = 1; k <= 8; k++) begin
                c = (last - k + 8) % 8;
                if (cand[c] && w < 0) w = c;
            end
        end
        return w;
    endfunction

    task automatic model_step();
        logic [7:0] cand;
        logic [7:0] g;
        logic [2:0] idx;
        logic       to;
        logic       v;
        int         w;
        to = 1'b0;
        if (m_owner < 0) begin
            cand = ~requestN;
            if (m_mask >= 0 && ($countones(cand) - int'(cand[m_mask])) >= 1) begin
                cand[m_mask] = 1'b0;
            end
            m_mask = -1;
            if (!enableN && cand != 8'h00) begin
                w       = pick_winner(cand, roundRobin, m_last);
                m_owner = w;
                m_held  = 1;
                m_last  = w;
            end
        end else begin
            if (requestN[m_owner]) begin
                m_owner = -1;
            end else if (m_held == MAX_HOLD) begin
                m_mask  = m_owner;
                m_owner = -1;
                to      = 1'b1;
            end else begin
                m_held++;
            end
        end
        v   = (m_owner >= 0);
        g   = 8'h00;
        idx = 3'd0;
        if (v) begin
            g[m_owner] = 1'b1;
            idx        = 3'(m_owner);
        end
        exp_q.push_back({v, g, idx, v, to});
    endtask

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 0;
            m_mask  = -1;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // ---------------- monitor ----------------
    always @(negedge resetN) begin
        prev_valid = 1'b0;
        run_len    = 0;
    end

    always @(negedge clock) begin
        logic [13:0] e;
        if (!resetN) begin
            check("reset_outputs", int'({debugState, grant, grantIndex, grantValid, timeout}), 0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", int'({debugState, grant, grantIndex, grantValid, timeout}), int'(e));
            if (grantValid && !prev_valid) own_log.push_back(int'(grantIndex));
            if (grantValid) run_len++;
            if (!grantValid && prev_valid) begin
                len_log.push_back(run_len);
                run_len = 0;
            end
            if (timeout) to_count++;
            prev_valid = grantValid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetN = 1'b0;
        wait_neg(2);
        resetN = 1'b1;
    endtask

    task automatic clear_logs();
        own_log.delete();
        len_log.delete();
        to_count = 0;
    endtask

    task automatic run_round_robin();
        int cnt;
        int rearm;
        cnt   = 0;
        rearm = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (rearm >= 0) begin
                requestN[rearm] = 1'b0;
                rearm = -1;
            end
            if (grantValid) begin
                cnt++;
                if (cnt == 2) begin
                    requestN[grantIndex] = 1'b1;
                    rearm = int'(grantIndex);
                    cnt   = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        wait_neg(3);
        resetN = 1'b1;
        wait_neg(2);

        // Fixed priority: 7 and 5 request, 7 releases after 3 grant cycles.
        clear_logs();
        roundRobin = 1'b0;
        enableN    = 1'b0;
        requestN   = 8'b0101_1111;
        wait_neg(3);
        requestN[7] = 1'b1;
        wait_neg(4);
        requestN = 8'hFF;
        wait_neg(6);
        check("fixed_first_owner", own_at(0), 7);
        check("fixed_first_len", len_at(0), 3);
        check("fixed_second_owner", own_at(1), 5);

        // Asynchronous reset in the middle of a grant to channel 3.
        clear_logs();
        requestN = 8'hF7;
        wait_neg(2);
        check("pre_reset_grant", int'(grant), 8'h08);
        #1 resetN = 1'b0;
        #1 check("reset_async_grant", int'({grant, grantValid}), 0);
        #1 resetN = 1'b1;
        #1 check("reset_release_no_grant", int'({grant, grantValid}), 0);
        @(posedge clock);
        #1 check("post_reset_grant", int'(grant), 8'h08);
        requestN = 8'hFF;
        wait_neg(4);

        // Round robin from a fresh pointer: 7, 4, 1, 7.
        do_reset();
        clear_logs();
        roundRobin = 1'b1;
        enableN    = 1'b0;
        requestN   = 8'b0110_1101;
        run_round_robin();
        requestN   = 8'hFF;
        roundRobin = 1'b0;
        wait_neg(4);
        check("rr_owner0", own_at(0), 7);
        check("rr_owner1", own_at(1), 4);
        check("rr_owner2", own_at(2), 1);
        check("rr_owner3", own_at(3), 7);
        check("rr_len0", len_at(0), 2);
        check("rr_len1", len_at(1), 2);

        // Timeout and mask with channels 6 and 2 held.
        clear_logs();
        requestN = 8'hBB;
        wait_neg(9);
        check("to_owner0", own_at(0), 6);
        check("to_len0", len_at(0), MAX_HOLD);
        check("to_owner1", own_at(1), 2);
        check("to_pulses", to_count, 1);
        requestN = 8'hFF;
        wait_neg(6);

        // Timed-out channel alone is re-granted after one idle cycle.
        clear_logs();
        requestN = 8'hBF;
        wait_neg(7);
        check("alone_owner0", own_at(0), 6);
        check("alone_owner1", own_at(1), 6);
        check("alone_len0", len_at(0), MAX_HOLD);
        check("alone_pulses", to_count, 1);
        requestN = 8'hFF;
        wait_neg(7);

        // Enable gating.
        clear_logs();
        enableN  = 1'b1;
        requestN = 8'h0F;
        wait_neg(5);
        check("enable_blocks", own_log.size(), 0);
        enableN = 1'b0;
        wait_neg(1);
        enableN = 1'b1;
        wait_neg(2);
        requestN[7] = 1'b1;
        wait_neg(5);
        check("enable_hold_owner", own_at(0), 7);
        check("enable_hold_len", len_at(0), 3);
        check("enable_no_regrant", own_log.size(), 1);
        requestN = 8'hFF;
        wait_neg(3);
        enableN = 1'b0;

        // Release on the same cycle holdCount reaches MAX_HOLD.
        clear_logs();
        requestN = 8'hF7;
        wait_neg(4);
        requestN = 8'hFF;
        wait_neg(1);
        requestN = 8'hF5;
        wait_neg(2);
        check("simul_len", len_at(0), MAX_HOLD);
        check("simul_no_timeout", to_count, 0);
        check("simul_unmasked_owner", own_at(1), 3);
        requestN = 8'hFF;
        wait_neg(6);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 3) == 0) requestN = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) enableN = ~enableN;
            if ($urandom_range(0, 15) == 0) roundRobin = ~roundRobin;
        end
        requestN = 8'hFF;
        wait_neg(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
